spi_slave_sync: RTL and testbench
=================================

SPI_SLAVE_SYNC -- requirements
Module: spi_slave_sync

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word length in bits (legal: 2 or more).
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = bit 0 shifted first, 0 = MSB first.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sclk/ss_n/mosi (legal: 2 or more).
REQ-004 SHALL have port s_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports cpol, cpha  in  1 each  SPI mode select.
REQ-007 SHALL have ports sclk, ss_n, mosi  in  1 each  asynchronous SPI pins.
REQ-008 SHALL have ports miso, miso_oe  out  1 each  serial data out and its output enable.
REQ-009 SHALL have ports tx_data  in  DATA_WIDTH; tx_valid  in  1; tx_ready  out  1  transmit-word handshake.
REQ-010 SHALL have ports rx_data  out  DATA_WIDTH; rx_valid  out  1; rx_ready  in  1  receive-word handshake.
REQ-011 SHALL have ports busy, overrun, underrun  out  1 each  status.

Function
REQ-012 SHALL pass sclk, ss_n and mosi through SYNC_STAGES flops, then detect edges by comparing the last stage with one extra registered copy.
REQ-013 SHALL define the leading edge as sclk leaving level cpol and the trailing edge as the return to cpol; the sample edge is leading when cpha=0 and trailing when cpha=1; the other edge is the shift edge.
REQ-014 SHALL use FSM states IDLE and ACTIVE: IDLE->ACTIVE on a synced ss_n falling edge; ACTIVE->IDLE on a synced ss_n rising edge; busy=1 in ACTIVE.
REQ-015 SHALL latch cpol/cpha on the IDLE->ACTIVE transition and ignore later changes until the next IDLE.
REQ-016 SHALL hold a one-word tx buffer: tx_ready = buffer empty (registered); accept on tx_valid&&tx_ready.
REQ-017 SHALL load tx shift register from buffer (buffer then empty) on IDLE->ACTIVE and on each word-completing sample edge; if buffer empty, SHALL load all zeros and pulse underrun for 1 cycle.
REQ-018 SHALL drive miso combinationally from the outgoing bit of tx shift register (bit 0 or MSB per LSB_FIRST); miso_oe=1 only in ACTIVE.
REQ-019 SHALL advance tx shift register on a shift edge only if at least one sample edge occurred since the last load (gives correct first-bit timing in both cpha values).
REQ-020 SHALL on each sample edge shift synced mosi into rx shift register in LSB_FIRST order and increment bit counter modulo DATA_WIDTH.
REQ-021 SHALL on the DATA_WIDTH-th sample edge copy the word to rx_data and set rx_valid the next cycle; rx_valid held until rx_valid&&rx_ready.
REQ-022 SHALL, if a new word completes while rx_valid=1 and rx_ready=0, overwrite rx_data, keep rx_valid=1 and pulse overrun for 1 cycle.
REQ-023 SHALL support back-to-back words within one ss_n-low frame with no gap bits.
REQ-024 SHALL, on ss_n rise mid-word, discard partial rx bits (no rx_valid), clear bit counter; an already-loaded tx word is lost (not returned to buffer).
REQ-025 SHALL ignore sclk edges in IDLE; simultaneous ss_n rise and sample edge: ss_n rise wins, sample discarded.
REQ-026 SHALL require s_clk frequency 4x or more sclk; behaviour is undefined below that.

Reset
REQ-027 SHALL on rst=1: state IDLE, tx buffer empty (tx_ready=1 the next cycle), shift registers and rx_data zero, bit counter 0, rx_valid/overrun/underrun/busy/miso_oe 0, synchronizer stages at idle values (ss_n=1, sclk=0, mosi=0).
REQ-028 SHALL, if asserted mid-frame, abort the frame; after release the FSM waits for a fresh ss_n falling edge.

Structure
REQ-029 SHALL place state encoding and mode constants (MODE0..MODE3 as {cpol,cpha}) in shared package spi_pkg.
REQ-030 SHALL implement synchronizer plus edge detect as sub-module spi_sync_edge (instanced 3x; only rise/fall outputs used for ss_n/sclk).

Verification
REQ-031 Mode 0, W=8, LSB_FIRST=1, tx 0xA5, master sends 0x3C -> master reads 0xA5, rx_data=0x3C, one rx_valid.
REQ-032 Modes 1,2,3 each, tx 0x81, mosi 0x7E, MSB_FIRST -> miso 0x81 and rx 0x7E in every mode.
REQ-033 Three back-to-back words, one ss_n frame, tx 0x11/0x22/0x33 refilled in time -> 0x11,0x22,0x33 out, three rx words, no underrun.
REQ-034 Tx buffer empty at frame start -> miso all zero, underrun pulse once.
REQ-035 rx_ready=0 across two words 0x01,0x02 -> overrun pulse, rx_data=0x02, rx_valid held.
REQ-036 ss_n raised after 5 bits, then rst mid-next-frame -> no rx_valid, busy=0, next full frame received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave slice.
//   ST_IDLE / ST_ACTIVE : frame state encoding
//   MODE0..MODE3        : SPI mode as {cpol, cpha}
//   edge_sel()          : maps a mode and the synced sclk edges to {sample, shift}
package spi_pkg;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACTIVE = 1'b1;

   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   // Leading edge leaves cpol, trailing edge returns to it.
   // cpha=0 samples on the leading edge, cpha=1 on the trailing edge.
   function automatic logic [1:0] edge_sel(input logic [1:0] mode,
                                           input logic       rise,
                                           input logic       fall);
      logic [1:0] res;
      res = '0;
      case (mode)
         MODE0:   res = {rise, fall};
         MODE1:   res = {fall, rise};
         MODE2:   res = {fall, rise};
         MODE3:   res = {rise, fall};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with edge detection for one asynchronous pin.
//   s_clk, rst : system clock, synchronous active-high reset
//   d          : asynchronous input pin
//   q          : synchronized level (last stage)
//   rise, fall : one-cycle pulses when q differs from its registered copy
module spi_sync_edge #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic s_clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   always_ff @(posedge s_clk) begin
      if (rst) begin
         chain <= {STAGES{RST_VAL}};
         prev  <= RST_VAL;
      end else begin
         chain <= {chain[STAGES-2:0], d};
         prev  <= chain[STAGES-1];
      end
   end

   assign q    = chain[STAGES-1];
   assign rise = q & ~prev;
   assign fall = ~q & prev;

endmodule

// File: rtl/spi_slave_sync.sv
// SPI slave, fully synchronous to s_clk (s_clk must be >= 4x sclk).
//   cpol, cpha          : SPI mode, latched at frame start
//   sclk, ss_n, mosi    : asynchronous SPI pins
//   miso, miso_oe       : serial data out, driven only while a frame is active
//   tx_data/valid/ready : one-word transmit buffer handshake
//   rx_data/valid/ready : received word handshake
//   busy                : frame active
//   overrun, underrun   : one-cycle status pulses
module spi_slave_sync
   import spi_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int LSB_FIRST   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  s_clk,
   input  logic                  rst,
   input  logic                  cpol,
   input  logic                  cpha,
   input  logic                  sclk,
   input  logic                  ss_n,
   input  logic                  mosi,
   output logic                  miso,
   output logic                  miso_oe,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic                  busy,
   output logic                  overrun,
   output logic                  underrun
);

   localparam int CW = $clog2(DATA_WIDTH);

   logic                  sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_s;
   logic                  sclk_q_unused, ss_q_unused, mosi_rise_unused, mosi_fall_unused;
   logic [0:0]            state;
   logic [1:0]            mode_q;
   logic [DATA_WIDTH-1:0] tx_buf, tx_sh, rx_sh, rx_next, tx_next;
   logic                  tx_full, sampled;
   logic [CW-1:0]         bit_cnt;
   logic [1:0]            edges;
   logic                  active, sample_ev, shift_ev, word_done, start, load;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .s_clk(s_clk), .rst(rst), .d(sclk),
      .q(sclk_q_unused), .rise(sclk_rise), .fall(sclk_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ss (
      .s_clk(s_clk), .rst(rst), .d(ss_n),
      .q(ss_q_unused), .rise(ss_rise), .fall(ss_fall));

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .s_clk(s_clk), .rst(rst), .d(mosi),
      .q(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused));

   always_comb begin
      edges     = edge_sel(mode_q, sclk_rise, sclk_fall);
      active    = (state == ST_ACTIVE);
      // ss_n rising wins over a coincident sample edge
      sample_ev = active && edges[1] && !ss_rise;
      shift_ev  = active && edges[0] && !ss_rise;
      word_done = sample_ev && (bit_cnt == CW'(DATA_WIDTH - 1));
      start     = !active && ss_fall;
      load      = start || word_done;
      if (LSB_FIRST != 0) begin
         rx_next = {mosi_s, rx_sh[DATA_WIDTH-1:1]};
         tx_next = {1'b0, tx_sh[DATA_WIDTH-1:1]};
      end else begin
         rx_next = {rx_sh[DATA_WIDTH-2:0], mosi_s};
         tx_next = {tx_sh[DATA_WIDTH-2:0], 1'b0};
      end
   end

   assign miso     = (LSB_FIRST != 0) ? tx_sh[0] : tx_sh[DATA_WIDTH-1];
   assign miso_oe  = active;
   assign busy     = active;
   assign tx_ready = !tx_full;

   always_ff @(posedge s_clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         mode_q   <= MODE0;
         tx_buf   <= '0;
         tx_full  <= 1'b0;
         tx_sh    <= '0;
         rx_sh    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         bit_cnt  <= '0;
         sampled  <= 1'b0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         overrun  <= 1'b0;
         underrun <= 1'b0;

         if (!active) begin
            if (ss_fall) begin
               state   <= ST_ACTIVE;
               mode_q  <= {cpol, cpha};
               bit_cnt <= '0;
            end
         end else if (ss_rise) begin
            // partial word and any loaded tx word are dropped
            state   <= ST_IDLE;
            bit_cnt <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            sampled <= 1'b0;
         end

         // load consumes the buffer only when full, accept only fills when empty
         if (load) begin
            tx_sh    <= tx_full ? tx_buf : '0;
            underrun <= !tx_full;
            tx_full  <= 1'b0;
            sampled  <= 1'b0;
         end else if (tx_valid && !tx_full) begin
            tx_buf  <= tx_data;
            tx_full <= 1'b1;
         end

         // hold the first bit of a fresh word until it has been sampled once
         if (!load && shift_ev && sampled)
            tx_sh <= tx_next;

         if (sample_ev) begin
            rx_sh <= rx_next;
            if (word_done) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + CW'(1);
               sampled <= 1'b1;
            end
         end

         if (word_done) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            overrun  <= rx_valid && !rx_ready;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
module tb_spi_slave_sync;
   import spi_pkg::*;

   localparam int W = 8;
   localparam int H = 6;   // sclk half period in s_clk cycles

   logic         s_clk = 1'b0;
   logic         rst   = 1'b1;
   logic         cpol  = 1'b0;
   logic         cpha  = 1'b0;
   logic         sclk  = 1'b0;
   logic         mosi  = 1'b0;
   logic [1:0]   ss_n     = 2'b11;
   logic [1:0]   tx_valid = 2'b00;
   logic [1:0]   rx_ready = 2'b11;
   logic [1:0]   miso, miso_oe, tx_ready, rx_valid, busy, overrun, underrun;
   logic [W-1:0] tx_data [2];
   logic [W-1:0] rx_data [2];

   always #5 s_clk = ~s_clk;

   spi_slave_sync #(.DATA_WIDTH(W), .LSB_FIRST(1), .SYNC_STAGES(2)) dut_lsb (
      .s_clk(s_clk), .rst(rst), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .ss_n(ss_n[0]), .mosi(mosi),
      .miso(miso[0]), .miso_oe(miso_oe[0]),
      .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
      .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]),
      .busy(busy[0]), .overrun(overrun[0]), .underrun(underrun[0]));

   spi_slave_sync #(.DATA_WIDTH(W), .LSB_FIRST(0), .SYNC_STAGES(3)) dut_msb (
      .s_clk(s_clk), .rst(rst), .cpol(cpol), .cpha(cpha),
      .sclk(sclk), .ss_n(ss_n[1]), .mosi(mosi),
      .miso(miso[1]), .miso_oe(miso_oe[1]),
      .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
      .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]),
      .busy(busy[1]), .overrun(overrun[1]), .underrun(underrun[1]));

   // ---------------- monitors ----------------
   int           ur_cnt [2] = '{0, 0};
   int           ov_cnt [2] = '{0, 0};
   logic [W-1:0] rxq0 [$];
   logic [W-1:0] rxq1 [$];

   always @(negedge s_clk) begin
      if (underrun[0]) ur_cnt[0]++;
      if (underrun[1]) ur_cnt[1]++;
      if (overrun[0])  ov_cnt[0]++;
      if (overrun[1])  ov_cnt[1]++;
      if (rx_valid[0] && rx_ready[0]) rxq0.push_back(rx_data[0]);
      if (rx_valid[1] && rx_ready[1]) rxq1.push_back(rx_data[1]);
   end

   // ---------------- bench state ----------------
   int           n_pass  = 0;
   int           n_fail  = 0;
   int           n_total = 0;
   int           s       = 0;      // selected instance
   logic [W-1:0] feedq [$];        // words still to hand to the tx buffer
   logic [W-1:0] m_out [4];        // master -> slave words
   logic [W-1:0] m_in  [4];        // words the master read from miso

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int rx_size(input int sel_i);
      return (sel_i == 0) ? rxq0.size() : rxq1.size();
   endfunction

   function automatic logic [W-1:0] rx_at(input int sel_i, input int i);
      if (i >= rx_size(sel_i)) return '0;
      return (sel_i == 0) ? rxq0[i] : rxq1[i];
   endfunction

   function automatic int bidx(input int k, input logic lsb);
      return lsb ? (k % W) : (W - 1 - (k % W));
   endfunction

   // one s_clk cycle; also feeds the tx buffer from feedq
   task automatic tick();
      logic acc;
      acc = tx_valid[s] && tx_ready[s];
      @(posedge s_clk);
      #1;
      if (acc) begin
         void'(feedq.pop_front());
         tx_valid[s] = 1'b0;
      end
      if (feedq.size() > 0 && !tx_valid[s]) begin
         tx_data[s]  = feedq[0];
         tx_valid[s] = 1'b1;
      end
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // SPI master: nw words, optional early ss_n rise, optional reset mid-frame,
   // optional tx word offered only after the frame has started
   task automatic frame(input int sel_i, input logic [1:0] mode, input int nw,
                        input int stop_bits, input int rst_bit, input int late_word);
      int   nbits;
      logic lsb;
      s    = sel_i;
      lsb  = (sel_i == 0);
      cpol = mode[1];
      cpha = mode[0];
      sclk = mode[1];
      mosi = 1'b0;
      for (int w = 0; w < 4; w++) m_in[w] = '0;
      tick_n(4);
      nbits = (stop_bits > 0) ? stop_bits : nw * W;
      if (!mode[0]) mosi = m_out[0][bidx(0, lsb)];
      ss_n[s] = 1'b0;
      tick_n(2 * H);
      if (late_word >= 0) feedq.push_back(late_word[W-1:0]);
      for (int k = 0; k < nbits; k++) begin
         if (rst_bit > 0 && k == rst_bit) begin
            rst = 1'b1;
            tick_n(3);
            chk("rst_busy", 32'(busy[s]), 32'd0);
            chk("rst_oe", 32'(miso_oe[s]), 32'd0);
            ss_n[s] = 1'b1;
            tick_n(2);
            rst = 1'b0;
            tick_n(2 * H);
            return;
         end
         if (k == 1) begin
            chk("frame_busy", 32'(busy[s]), 32'd1);
            chk("frame_oe", 32'(miso_oe[s]), 32'd1);
         end
         if (!mode[0]) begin
            m_in[k / W][bidx(k, lsb)] = miso[s];
            sclk = ~mode[1];
            tick_n(H);
            sclk = mode[1];
            if (k + 1 < nbits) mosi = m_out[(k + 1) / W][bidx(k + 1, lsb)];
            tick_n(H);
         end else begin
            sclk = ~mode[1];
            mosi = m_out[k / W][bidx(k, lsb)];
            tick_n(H);
            m_in[k / W][bidx(k, lsb)] = miso[s];
            sclk = mode[1];
            tick_n(H);
         end
      end
      ss_n[s] = 1'b1;
      tick_n(2 * H);
   endtask

   // Full frame checked against the model: word k out on miso is the k-th queued
   // tx word (zero if none); every mosi word is received; one load per frame start
   // plus one per completed word, each empty load being an underrun.
   task automatic xfer_check(input string tag, input int sel_i, input logic [1:0] mode, input int nw);
      int           rx0, ur0, nf, exp_ur;
      logic [W-1:0] fed [$];
      fed = feedq;
      nf  = fed.size();
      rx0 = rx_size(sel_i);
      ur0 = ur_cnt[sel_i];
      frame(sel_i, mode, nw, 0, 0, -1);
      for (int w = 0; w < nw; w++) begin
         chk({tag, "_miso"}, 32'(m_in[w]), (w < nf) ? 32'(fed[w]) : 32'd0);
         chk({tag, "_rx"}, 32'(rx_at(sel_i, rx0 + w)), 32'(m_out[w]));
      end
      chk({tag, "_rxcnt"}, 32'(rx_size(sel_i) - rx0), 32'(nw));
      exp_ur = (nw + 1 > nf) ? (nw + 1 - nf) : 0;
      chk({tag, "_under"}, 32'(ur_cnt[sel_i] - ur0), 32'(exp_ur));
   endtask

   initial begin
      int rx0, ur0, ov0, nf;
      tx_data[0] = '0;
      tx_data[1] = '0;

      // reset
      rst = 1'b1;
      tick_n(3);
      rst = 1'b0;
      tick_n(1);
      for (int i = 0; i < 2; i++) begin
         chk("rst_tx_ready", 32'(tx_ready[i]), 32'd1);
         chk("rst_busy0", 32'(busy[i]), 32'd0);
         chk("rst_miso_oe", 32'(miso_oe[i]), 32'd0);
         chk("rst_rx_valid", 32'(rx_valid[i]), 32'd0);
         chk("rst_rx_data", 32'(rx_data[i]), 32'd0);
         chk("rst_flags", 32'({overrun[i], underrun[i]}), 32'd0);
         chk("rst_miso", 32'(miso[i]), 32'd0);
      end

      // mode 0, LSB first: tx A5, master sends 3C
      feedq.push_back(8'hA5);
      m_out[0] = 8'h3C;
      xfer_check("m0_basic", 0, MODE0, 1);

      // modes 1..3, MSB first: tx 81, master sends 7E
      for (int md = 1; md < 4; md++) begin
         feedq.push_back(8'h81);
         m_out[0] = 8'h7E;
         xfer_check($sformatf("msb_m%0d", md), 1, 2'(md), 1);
      end

      // random data, random buffer fill level, all modes, both bit orders
      for (int sel = 0; sel < 2; sel++) begin
         for (int md = 0; md < 4; md++) begin
            nf = int'($urandom_range(0, 3));
            for (int j = 0; j < nf; j++) feedq.push_back(W'($urandom));
            m_out[0] = W'($urandom);
            m_out[1] = W'($urandom);
            xfer_check($sformatf("rnd_s%0d_m%0d", sel, md), sel, 2'(md), 2);
         end
      end

      // three back-to-back words; a fourth word covers the final load
      feedq.push_back(8'h11);
      feedq.push_back(8'h22);
      feedq.push_back(8'h33);
      feedq.push_back(W'($urandom));
      for (int w = 0; w < 3; w++) m_out[w] = W'($urandom);
      xfer_check("b2b", 0, MODE3, 3);

      // empty buffer at frame start, refilled during the word
      rx0 = rx_size(0);
      ur0 = ur_cnt[0];
      m_out[0] = W'($urandom);
      frame(0, MODE0, 1, 0, 0, 32'h5A);
      chk("empty_miso", 32'(m_in[0]), 32'd0);
      chk("empty_under", 32'(ur_cnt[0] - ur0), 32'd1);
      chk("empty_rx", 32'(rx_at(0, rx0)), 32'(m_out[0]));

      // overrun: rx_ready low across two words
      rx_ready[0] = 1'b0;
      for (int j = 0; j < 3; j++) feedq.push_back(W'($urandom));
      m_out[0] = 8'h01;
      m_out[1] = 8'h02;
      rx0 = rx_size(0);
      ov0 = ov_cnt[0];
      frame(0, MODE1, 2, 0, 0, -1);
      chk("ovr_pulse", 32'(ov_cnt[0] - ov0), 32'd1);
      chk("ovr_valid", 32'(rx_valid[0]), 32'd1);
      chk("ovr_data", 32'(rx_data[0]), 32'h02);
      chk("ovr_nohs", 32'(rx_size(0) - rx0), 32'd0);
      rx_ready[0] = 1'b1;
      tick_n(2);
      chk("ovr_hs_cnt", 32'(rx_size(0) - rx0), 32'd1);
      chk("ovr_hs_data", 32'(rx_at(0, rx0)), 32'h02);
      chk("ovr_cleared", 32'(rx_valid[0]), 32'd0);

      // ss_n raised after 5 bits
      feedq.push_back(W'($urandom));
      m_out[0] = W'($urandom);
      rx0 = rx_size(0);
      ur0 = ur_cnt[0];
      frame(0, MODE0, 1, 5, 0, -1);
      chk("abort_rx", 32'(rx_size(0) - rx0), 32'd0);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      chk("abort_under", 32'(ur_cnt[0] - ur0), 32'd0);
      chk("abort_valid", 32'(rx_valid[0]), 32'd0);

      // reset in the middle of the next frame
      feedq.push_back(W'($urandom));
      m_out[0] = W'($urandom);
      frame(0, MODE2, 1, 0, 3, -1);
      chk("rstmid_rx", 32'(rx_size(0) - rx0), 32'd0);
      chk("rstmid_busy", 32'(busy[0]), 32'd0);
      chk("rstmid_ready", 32'(tx_ready[0]), 32'd1);

      // full frame afterwards
      feedq.push_back(W'($urandom));
      feedq.push_back(W'($urandom));
      m_out[0] = W'($urandom);
      xfer_check("post_rst", 0, MODE0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
